enc8to3_seq: RTL and testbench

- Sequential 8-to-3 encoder; the counterpart of the team's 3-to-8 decoder.
- Captures an 8-bit request vector (one-hot or multi-hot) through a valid/ready handshake.
- Emits the 3-bit index of every set bit, one per accepted transfer, in priority order.
- Sits between request-vector sources (interrupt/request lines) and index-based consumers that feed the decoder.

---
 rtl/enc8to3_if.sv | 29 ++
 rtl/enc8to3_seq.sv | 148 ++++++++++++++
 tb/tb_enc8to3_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/enc8to3_if.sv
// Request/response bundle for the sequential 8-to-3 encoder.
// Request side:  in[7:0], in_valid -> in_ready
// Response side: out[2:0], out_valid, last, cnt[3:0], none -> out_ready
// slave modport is used by the encoder; master modport by the producer/consumer.
interface enc8to3_if;
    localparam int unsigned IN_W  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             none;

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, last, cnt, none
    );

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, last, cnt, none
    );
endinterface

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of
// every set bit, one per accepted output transfer, in priority order.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   en   - active-high enable; 0 freezes all state
//   bus  - enc8to3_if.slave: in/in_valid/in_ready (in_ready is combinational),
//          out/out_valid/out_ready, last, cnt, none (all registered)
// PRIORITY_LSB = 1 emits the lowest set index first, 0 the highest first.
module enc8to3_seq #(
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    enc8to3_if.slave      bus
);
    localparam int unsigned IN_W  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [IN_W-1:0]  pending_q,   pending_d;
    logic [IDX_W-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q,      last_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             none_q,      none_d;

    logic             in_ready_c;
    logic             capture_c;
    logic             pop_c;
    logic [IN_W-1:0]  remain_c;
    logic [CNT_W-1:0] in_count_c;

    // Index of the highest-priority set bit; 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] prio_idx(input logic [IN_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (PRIORITY_LSB) begin
            // Scan downward so the lowest set bit is written last.
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits (0..8).
    function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < IN_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Handshake qualifiers.
    assign in_ready_c = (state_q == IDLE) && en;
    assign capture_c  = bus.in_valid && in_ready_c;
    assign pop_c      = out_valid_q && bus.out_ready && en;
    assign remain_c   = pending_q & ~(IN_W'(1) << out_q);
    assign in_count_c = popcount(bus.in);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        none_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture_c) begin
                    if (bus.in != '0) begin
                        pending_d   = bus.in;
                        out_d       = prio_idx(bus.in);
                        out_valid_d = 1'b1;
                        cnt_d       = in_count_c;
                        last_d      = (in_count_c == CNT_W'(1));
                        state_d     = EMIT;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (pop_c) begin
                    pending_d = remain_c;
                    if (remain_c != '0) begin
                        out_d  = prio_idx(remain_c);
                        cnt_d  = cnt_q - CNT_W'(1);
                        // The next index is the final one when two were left before this pop.
                        last_d = (cnt_q == CNT_W'(2));
                    end else begin
                        out_valid_d = 1'b0;
                        last_d      = 1'b0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            none_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            none_q      <= none_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.last      = last_q;
    assign bus.cnt       = cnt_q;
    assign bus.none      = none_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: one LSB-first and one MSB-first instance driven with
// identical stimulus; expected emissions are queued per instance and checked
// by independent monitors on every output transfer.
module tb_enc8to3_seq;
    typedef struct {
        logic [2:0] idx;
        logic [3:0] cnt;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] in_v = 8'h00;
    logic       in_valid_v = 1'b0;
    logic       out_ready_v = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t q_l[$];
    exp_t q_m[$];

    enc8to3_if if_l();
    enc8to3_if if_m();

    assign if_l.in        = in_v;
    assign if_l.in_valid  = in_valid_v;
    assign if_l.out_ready = out_ready_v;
    assign if_m.in        = in_v;
    assign if_m.in_valid  = in_valid_v;
    assign if_m.out_ready = out_ready_v;

    enc8to3_seq #(.PRIORITY_LSB(1'b1)) dut_l (.clk(clk), .rst(rst), .en(en), .bus(if_l));
    enc8to3_seq #(.PRIORITY_LSB(1'b0)) dut_m (.clk(clk), .rst(rst), .en(en), .bus(if_m));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected emission order for both priority settings.
    task automatic push_expected(input logic [7:0] v);
        int idx_list[$];
        int n;
        exp_t e;
        for (int i = 0; i < 8; i++) if (v[i]) idx_list.push_back(i);
        n = idx_list.size();
        for (int k = 0; k < n; k++) begin
            e.idx  = 3'(idx_list[k]);
            e.cnt  = 4'(n - k);
            e.last = (k == n - 1);
            q_l.push_back(e);
            e.idx  = 3'(idx_list[n - 1 - k]);
            q_m.push_back(e);
        end
    endtask

    task automatic capture(input logic [7:0] v);
        int n = 0;
        in_v = v;
        in_valid_v = 1'b1;
        while (!if_l.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!if_l.in_ready) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: in_ready got 0 expected 1");
        end
        push_expected(v);
        step();
        in_valid_v = 1'b0;
    endtask

    // Monitors: a transfer happens at the next posedge when valid, ready and en are high.
    always @(negedge clk) begin
        if (!rst && en && if_l.out_valid && if_l.out_ready) begin
            checks++;
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL mon_l: got idx=%0d with no expected transfer", if_l.out);
            end else begin
                exp_t e;
                e = q_l.pop_front();
                if (if_l.out !== e.idx || if_l.cnt !== e.cnt || if_l.last !== e.last) begin
                    errors++;
                    $display("FAIL mon_l: got idx=%0d cnt=%0d last=%0b expected idx=%0d cnt=%0d last=%0b",
                             if_l.out, if_l.cnt, if_l.last, e.idx, e.cnt, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && en && if_m.out_valid && if_m.out_ready) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL mon_m: got idx=%0d with no expected transfer", if_m.out);
            end else begin
                exp_t e;
                e = q_m.pop_front();
                if (if_m.out !== e.idx || if_m.cnt !== e.cnt || if_m.last !== e.last) begin
                    errors++;
                    $display("FAIL mon_m: got idx=%0d cnt=%0d last=%0b expected idx=%0d cnt=%0d last=%0b",
                             if_m.out, if_m.cnt, if_m.last, e.idx, e.cnt, e.last);
                end
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1;
        en = 1'b1;
        step();
        step();
        chk("rst_out_l", 32'(if_l.out), 0);
        chk("rst_valid_l", 32'(if_l.out_valid), 0);
        chk("rst_last_l", 32'(if_l.last), 0);
        chk("rst_cnt_l", 32'(if_l.cnt), 0);
        chk("rst_none_l", 32'(if_l.none), 0);
        chk("rst_ready_l", 32'(if_l.in_ready), 1);
        chk("rst_valid_m", 32'(if_m.out_valid), 0);
        rst = 1'b0;
        step();
        chk("post_rst_valid", 32'(if_l.out_valid), 0);
        chk("post_rst_ready", 32'(if_l.in_ready), 1);

        // Single bit
        out_ready_v = 1'b1;
        capture(8'b0001_0000);
        chk("single_out_l", 32'(if_l.out), 4);
        chk("single_out_m", 32'(if_m.out), 4);
        chk("single_valid", 32'(if_l.out_valid), 1);
        chk("single_last", 32'(if_l.last), 1);
        chk("single_cnt", 32'(if_l.cnt), 1);
        step();
        chk("single_done_valid", 32'(if_l.out_valid), 0);
        chk("single_done_ready", 32'(if_l.in_ready), 1);

        // Multi-hot streaming: four pops on consecutive cycles
        capture(8'b1010_0110);
        chk("stream_first_l", 32'(if_l.out), 1);
        chk("stream_first_m", 32'(if_m.out), 7);
        chk("stream_first_cnt", 32'(if_l.cnt), 4);
        for (int i = 0; i < 4; i++) step();
        chk("stream_done_valid", 32'(if_l.out_valid), 0);
        chk("stream_done_ready", 32'(if_l.in_ready), 1);

        // All ones: cnt starts at 8
        capture(8'hFF);
        chk("ff_cnt", 32'(if_m.cnt), 8);
        chk("ff_first_m", 32'(if_m.out), 7);
        for (int i = 0; i < 8; i++) step();
        chk("ff_done_valid", 32'(if_m.out_valid), 0);

        // Backpressure and stall
        out_ready_v = 1'b0;
        capture(8'b0100_1000);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_l", 32'(if_l.out), 3);
            chk("bp_out_m", 32'(if_m.out), 6);
            chk("bp_valid", 32'(if_l.out_valid), 1);
            step();
        end
        in_v = 8'h01;
        in_valid_v = 1'b1;
        chk("emit_ready", 32'(if_l.in_ready), 0);
        step();
        in_valid_v = 1'b0;
        en = 1'b0;
        out_ready_v = 1'b1;
        step();
        step();
        chk("stall_out_l", 32'(if_l.out), 3);
        chk("stall_cnt", 32'(if_l.cnt), 2);
        chk("stall_valid", 32'(if_l.out_valid), 1);
        en = 1'b1;
        step();
        chk("resume_out_l", 32'(if_l.out), 6);
        chk("resume_last", 32'(if_l.last), 1);
        step();
        chk("resume_done", 32'(if_l.out_valid), 0);

        // Zero vector
        capture(8'h00);
        chk("none_pulse", 32'(if_l.none), 1);
        chk("none_valid", 32'(if_l.out_valid), 0);
        chk("none_ready", 32'(if_l.in_ready), 1);
        step();
        chk("none_clear", 32'(if_l.none), 0);

        // Reset mid-emit after the first pop
        capture(8'b1100_0000);
        step();
        rst = 1'b1;
        out_ready_v = 1'b0;
        step();
        chk("midrst_valid", 32'(if_l.out_valid), 0);
        chk("midrst_cnt", 32'(if_l.cnt), 0);
        chk("midrst_ready", 32'(if_l.in_ready), 1);
        chk("midrst_valid_m", 32'(if_m.out_valid), 0);
        q_l.delete();
        q_m.delete();
        rst = 1'b0;
        out_ready_v = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("midrst_no_emit", 32'(if_l.out_valid), 0);

        chk("q_l_empty", 32'(q_l.size()), 0);
        chk("q_m_empty", 32'(q_m.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
